// File: rtl/area_scan_pkg.sv
// ============================================================================
// area_scan_pkg : shared FSM encoding and width helper for the area scan copier
// Rev 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package area_scan_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_READ  = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_FIN   = 4'b1000
  } state_e;

  function automatic int ch_sel_w(input int dst_addr_w, input int ch_addr_w);
    return dst_addr_w - ch_addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/area_scan_rd_pipe.sv
// ============================================================================
// area_scan_rd_pipe : RD_LAT-deep {valid, addr} shift matching channel RAM latency
// Rev 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module area_scan_rd_pipe #(
  parameter int RD_LAT     = 2,
  parameter int DST_ADDR_W = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_i,
  input  logic [DST_ADDR_W-1:0] addr_i,
  output logic                  vld_o,
  output logic [DST_ADDR_W-1:0] addr_o,
  output logic                  busy_o
);

  logic [RD_LAT-1:0]     vld_q;
  logic [DST_ADDR_W-1:0] addr_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) addr_q[s] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      addr_q[0] <= addr_i;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s]  <= vld_q[s-1];
        addr_q[s] <= addr_q[s-1];
      end
    end
  end

  assign vld_o  = vld_q[RD_LAT-1];
  assign addr_o = addr_q[RD_LAT-1];
  assign busy_o = |vld_q;

endmodule

`default_nettype wire

// File: rtl/area_scan_mux_gen.sv
// ============================================================================
// area_scan_mux_gen : copies one aligned burst from a channel RAM into CUDB RAM.
// Optional burst checksum enabled by defining AREA_SCAN_CHKSUM_EN.
// Rev 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module area_scan_mux_gen
  import area_scan_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int DATA_W     = 8,
  parameter int CH_ADDR_W  = 10,
  parameter int DST_ADDR_W = 13,
  parameter int BURST_LEN  = 128,
  parameter int BASE_W     = 6,
  parameter int RD_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [BASE_W-1:0]             im_base_addr,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  output logic                          o_cudb_wren,
  output logic [DST_ADDR_W-1:0]         om_cudb_addr,
  output logic [DATA_W-1:0]             om_cudb_din,
  output logic [NUM_CH*CH_ADDR_W-1:0]   om_ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]      im_ch_rdata,
  output logic [DATA_W-1:0]             o_chksum
);

  localparam int                BURST_LOG = $clog2(BURST_LEN);
  localparam int                CNT_W     = BURST_LOG + 1;
  localparam int                CH_SEL_W  = ch_sel_w(DST_ADDR_W, CH_ADDR_W);
  localparam logic [CH_SEL_W:0] NUM_CH_L  = (CH_SEL_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_LEN - 1);

  state_e                        state_q;
  logic [DST_ADDR_W-1:0]         src_q, start_src_d;
  logic [CH_SEL_W-1:0]           ch_q, start_ch_d;
  logic [CNT_W-1:0]              cnt_q;
  logic                          ch_ok_d, start_ok_d;
  logic                          busy_q, done_q, err_q;
  logic [NUM_CH*CH_ADDR_W-1:0]   ch_addr_q, ch_addr_d;
  logic                          rd_vld_q;
  logic [DST_ADDR_W-1:0]         rd_addr_q;
  logic                          pipe_vld, pipe_busy;
  logic [DST_ADDR_W-1:0]         pipe_addr;
  logic                          wren_q;
  logic [DST_ADDR_W-1:0]         wr_addr_q;
  logic [DATA_W-1:0]             din_q, rdata_sel_d;

  assign start_src_d = DST_ADDR_W'(im_base_addr) << BURST_LOG;
  assign start_ch_d  = start_src_d[DST_ADDR_W-1:CH_ADDR_W];
  assign ch_ok_d     = {1'b0, start_ch_d} < NUM_CH_L;
  assign start_ok_d  = (state_q == ST_IDLE) && i_start && ch_ok_d;

  // Only the latched channel sees the running address; the rest stay parked at 0.
  always_comb begin
    ch_addr_d   = '0;
    rdata_sel_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(ch_q) == k) begin
        ch_addr_d[k*CH_ADDR_W +: CH_ADDR_W] = src_q[CH_ADDR_W-1:0];
        rdata_sel_d                         = im_ch_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  area_scan_rd_pipe #(
    .RD_LAT     (RD_LAT),
    .DST_ADDR_W (DST_ADDR_W)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (rd_vld_q),
    .addr_i (rd_addr_q),
    .vld_o  (pipe_vld),
    .addr_o (pipe_addr),
    .busy_o (pipe_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      ch_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ch_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      wren_q    <= 1'b0;
      wr_addr_q <= '0;
      din_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      ch_addr_q <= '0;
      wren_q    <= pipe_vld;
      wr_addr_q <= pipe_vld ? pipe_addr : '0;
      din_q     <= pipe_vld ? rdata_sel_d : '0;

      case (state_q)
        ST_IDLE: begin
          if (start_ok_d) begin
            src_q   <= start_src_d;
            ch_q    <= start_ch_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_READ;
          end else if (i_start) begin
            err_q <= 1'b1;
          end
        end
        ST_READ: begin
          ch_addr_q <= ch_addr_d;
          rd_vld_q  <= 1'b1;
          rd_addr_q <= src_q;
          src_q     <= src_q + DST_ADDR_W'(1);
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Empty pipe here means the final write is on the bus this cycle.
          if (!rd_vld_q && !pipe_busy) begin
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef AREA_SCAN_CHKSUM_EN
  logic [DATA_W-1:0] chk_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok_d) chk_q <= '0;
    else if (pipe_vld)     chk_q <= chk_q + rdata_sel_d;
  end

  assign o_chksum = chk_q;
`else
  assign o_chksum = '0;
`endif

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_cudb_wren  = wren_q;
  assign om_cudb_addr = wr_addr_q;
  assign om_cudb_din  = din_q;
  assign om_ch_addr   = ch_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_area_scan_mux_gen.sv
// ============================================================================
// tb_area_scan_mux_gen : scoreboard bench for area_scan_mux_gen with RAM models
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_area_scan_mux_gen;

  localparam int NUM_CH     = 6;
  localparam int DATA_W     = 8;
  localparam int CH_ADDR_W  = 10;
  localparam int DST_ADDR_W = 13;
  localparam int BURST_LEN  = 128;
  localparam int BASE_W     = 6;
  localparam int RD_LAT     = 2;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        i_start = 1'b0;
  logic [BASE_W-1:0]           im_base_addr = '0;
  logic                        o_busy, o_done, o_err, o_cudb_wren;
  logic [DST_ADDR_W-1:0]       om_cudb_addr;
  logic [DATA_W-1:0]           om_cudb_din, o_chksum;
  logic [NUM_CH*CH_ADDR_W-1:0] om_ch_addr;
  logic [NUM_CH*DATA_W-1:0]    im_ch_rdata;

  area_scan_mux_gen #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_ADDR_W(CH_ADDR_W), .DST_ADDR_W(DST_ADDR_W),
    .BURST_LEN(BURST_LEN), .BASE_W(BASE_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .im_base_addr(im_base_addr),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_cudb_wren(o_cudb_wren),
    .om_cudb_addr(om_cudb_addr), .om_cudb_din(om_cudb_din), .om_ch_addr(om_ch_addr),
    .im_ch_rdata(im_ch_rdata), .o_chksum(o_chksum)
  );

  always #5 clk = ~clk;

  // Channel k holds (addr + 17*(k-1)) mod 256, so channel 1 holds the address low byte.
  function automatic logic [DATA_W-1:0] ram_word(input int k, input logic [CH_ADDR_W-1:0] a);
    return DATA_W'(int'(a) + 17 * k - 17);
  endfunction

  function automatic logic [NUM_CH*DATA_W-1:0] ram_read(input logic [NUM_CH*CH_ADDR_W-1:0] addrs);
    logic [NUM_CH*DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++)
      r[k*DATA_W +: DATA_W] = ram_word(k, addrs[k*CH_ADDR_W +: CH_ADDR_W]);
    return r;
  endfunction

  logic [NUM_CH*DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    rd_pipe[0] <= ram_read(om_ch_addr);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign im_ch_rdata = rd_pipe[RD_LAT-1];

  typedef struct packed {
    logic [DST_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_t;

  wr_t              exp_q[$];
  int               n_tests = 0;
  int               n_fail = 0;
  int               wr_cnt = 0;
  int               viol = 0;
  int               issue_k = 0;
  int               burst_ch = 0;
  int               lowbase = 0;
  bit               track = 1'b0;
  logic [DATA_W-1:0] exp_sum = '0;
  int               cy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge and score them.
  task automatic tick();
    wr_t e;
    logic [CH_ADDR_W-1:0] ea;
    @(posedge clk);
    #1;
    issue_k++;
    if (o_cudb_wren) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_wren", 32'(o_cudb_wren), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(om_cudb_addr), 32'(e.addr));
        check_eq("wr_data", 32'(om_cudb_din), 32'(e.data));
      end
    end else if (om_cudb_din != '0) begin
      viol++;
    end
    if (track && issue_k >= 2 && issue_k <= BURST_LEN + 1) begin
      for (int k = 0; k < NUM_CH; k++) begin
        ea = (k == burst_ch) ? CH_ADDR_W'(lowbase + issue_k - 2) : '0;
        if (om_ch_addr[k*CH_ADDR_W +: CH_ADDR_W] !== ea) viol++;
      end
    end
  endtask

  task automatic start_burst(input int base);
    int  start;
    wr_t e;
    start    = base * BURST_LEN;
    burst_ch = start >> CH_ADDR_W;
    lowbase  = start % (1 << CH_ADDR_W);
    exp_sum  = '0;
    wr_cnt   = 0;
    viol     = 0;
    track    = (burst_ch < NUM_CH);
    if (burst_ch < NUM_CH) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        e.addr = DST_ADDR_W'(start + i);
        e.data = ram_word(burst_ch, CH_ADDR_W'(lowbase + i));
        exp_q.push_back(e);
        exp_sum = exp_sum + e.data;
      end
    end
    im_base_addr = BASE_W'(base);
    i_start      = 1'b1;
    issue_k      = 0;
    tick();
    i_start      = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int n = 0; n < 400; n++) begin
      if (o_done) begin
        cycles = issue_k;
        break;
      end
      tick();
    end
    if (cycles < 0) check_eq("done_timeout", 32'(o_done), 32'd1);
  endtask

  task automatic check_burst_end(input string tag, input logic [DATA_W-1:0] exp_chk);
    wait_done(cy);
    check_eq({tag, "_latency"}, 32'(cy), 32'd133);
    check_eq({tag, "_busy_at_done"}, 32'(o_busy), 32'd1);
`ifdef AREA_SCAN_CHKSUM_EN
    check_eq({tag, "_chksum"}, 32'(o_chksum), 32'(exp_chk));
`else
    check_eq({tag, "_chksum"}, 32'(o_chksum), 32'd0);
`endif
    tick();
    check_eq({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    check_eq({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_wr_count"}, 32'(wr_cnt), 32'(BURST_LEN));
    check_eq({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_addr_din_viol"}, 32'(viol), 32'd0);
    track = 1'b0;
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_done"}, 32'(o_done), 32'd0);
    check_eq({tag, "_err"}, 32'(o_err), 32'd0);
    check_eq({tag, "_wren"}, 32'(o_cudb_wren), 32'd0);
    check_eq({tag, "_waddr"}, 32'(om_cudb_addr), 32'd0);
    check_eq({tag, "_din"}, 32'(om_cudb_din), 32'd0);
    check_eq({tag, "_ch_addr"}, 32'(om_ch_addr), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    check_eq("reset_chksum", 32'(o_chksum), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // base 0 -> channel 0, CUDB 0..127
    start_burst(0);
    check_eq("t1_busy_after_start", 32'(o_busy), 32'd1);
    check_burst_end("t1", exp_sum);

    // base 40 -> channel 5, CUDB 5120..5247
    start_burst(40);
    check_burst_end("t2", exp_sum);

    // base 48 -> channel 6 is out of range
    start_burst(48);
    check_eq("t3_err_pulse", 32'(o_err), 32'd1);
    check_eq("t3_busy", 32'(o_busy), 32'd0);
    tick();
    check_eq("t3_err_clear", 32'(o_err), 32'd0);
    check_eq("t3_busy_later", 32'(o_busy), 32'd0);
    repeat (5) tick();
    check_eq("t3_no_writes", 32'(wr_cnt), 32'd0);

    // base 16 burst, with a second start at burst cycle 50 that must be ignored
    start_burst(16);
    while (issue_k < 49) tick();
    im_base_addr = BASE_W'(8);
    i_start      = 1'b1;
    tick();
    i_start      = 1'b0;
    check_burst_end("t4", exp_sum);

    // reset in the cycle after write #60 is seen
    start_burst(24);
    for (int n = 0; n < 300 && wr_cnt < 60; n++) tick();
    check_eq("t5_reached_60", 32'(wr_cnt), 32'd60);
    track = 1'b0;
    rst   = 1'b1;
    tick();
    check_idle_outputs("t5_rst");
    rst = 1'b0;
    exp_q.delete();
    repeat (10) tick();
    check_eq("t5_no_more_writes", 32'(wr_cnt), 32'd60);

    // base 8 -> channel 1 holds address low byte; checksum sum(0..127) mod 256
    start_burst(8);
    check_burst_end("t6", 8'hC0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
